bpsk_tx_ctrl: RTL and testbench

//  Frame scheduler for the BPSK transmit path. It accepts payload bytes over a valid/ready stream.

---
 rtl/bpsk_tx_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_bpsk_tx_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_tx_ctrl.sv
// BPSK transmit frame scheduler: alternating preamble, MSB-first payload, silent guard gap.
// Define DIFF_ENC_EN to differentially encode the payload bits (preamble unchanged).
module bpsk_tx_ctrl #(
    parameter int SPS     = 16,
    parameter int PRE_LEN = 8,
    parameter int GAP_LEN = 4,
    parameter int BWIDTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [BWIDTH-1:0] base_sig,
    output logic              duc_en,
    output logic              sym_strobe,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);
    localparam int CW      = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int IDX_MAX = (PRE_LEN > GAP_LEN) ? ((PRE_LEN > 8) ? PRE_LEN : 8)
                                                 : ((GAP_LEN > 8) ? GAP_LEN : 8);
    localparam int IW      = $clog2(IDX_MAX);

    localparam logic [BWIDTH-1:0] SYM_POS = BWIDTH'(1);
    localparam logic [BWIDTH-1:0] SYM_NEG = '1;
    localparam logic [BWIDTH-1:0] SYM_OFF = '0;

    typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

    state_t            state_reg;
    logic [CW-1:0]     sym_cnt_reg;
    logic [IW-1:0]     sym_idx_reg;
    logic [7:0]        hold_reg;
    logic              hold_full_reg;
    logic              hold_last_reg;
    logic [7:0]        shift_reg;
    logic              cur_last_reg;
    logic [BWIDTH-1:0] base_sig_reg;
    logic              duc_en_reg;
    logic              sym_strobe_reg;
    logic              busy_reg;
    logic              frame_done_reg;
    logic              underrun_reg;
`ifdef DIFF_ENC_EN
    logic              diff_reg;
`endif

    logic       xfer;
    logic       sym_end;
    logic       pre_end;
    logic       bit_end;
    logic       byte_load;
    logic       last_done;
    logic       src_avail;
    logic       bypass;
    logic [7:0] src_byte;
    logic       src_last;
    logic       raw_bit;
    logic       enc_bit;

    assign s_ready = !rst && !hold_full_reg && (state_reg != GAP) && ((state_reg != IDLE) || tx_en);
    assign xfer    = s_valid && s_ready;

    always_comb begin
        sym_end   = (sym_cnt_reg == CW'(SPS - 1));
        pre_end   = (state_reg == PRE) && sym_end && (sym_idx_reg == IW'(PRE_LEN - 1));
        bit_end   = (state_reg == DATA) && sym_end && (sym_idx_reg == IW'(7));
        byte_load = pre_end || (bit_end && !cur_last_reg);
        last_done = bit_end && cur_last_reg;
        src_avail = hold_full_reg || s_valid;
        // With hold empty the producer's byte goes straight to the shifter in the boundary cycle.
        bypass    = byte_load && !hold_full_reg && s_valid;
        src_byte  = hold_full_reg ? hold_reg : s_data;
        src_last  = hold_full_reg ? hold_last_reg : s_last;
        raw_bit   = byte_load ? src_byte[7] : shift_reg[6];
`ifdef DIFF_ENC_EN
        enc_bit   = raw_bit ^ diff_reg;
`else
        enc_bit   = raw_bit;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            sym_cnt_reg    <= '0;
            sym_idx_reg    <= '0;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
            hold_last_reg  <= 1'b0;
            shift_reg      <= '0;
            cur_last_reg   <= 1'b0;
            base_sig_reg   <= SYM_OFF;
            duc_en_reg     <= 1'b0;
            sym_strobe_reg <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;
`ifdef DIFF_ENC_EN
            diff_reg       <= 1'b0;
`endif
        end else begin
            sym_strobe_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            underrun_reg   <= 1'b0;

            if (xfer && !bypass) begin
                hold_reg      <= s_data;
                hold_last_reg <= s_last;
                hold_full_reg <= 1'b1;
            end else if (byte_load && hold_full_reg) begin
                hold_full_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (xfer) begin
                        state_reg      <= PRE;
                        base_sig_reg   <= SYM_POS;
                        duc_en_reg     <= 1'b1;
                        busy_reg       <= 1'b1;
                        sym_strobe_reg <= 1'b1;
                        sym_cnt_reg    <= '0;
                        sym_idx_reg    <= '0;
`ifdef DIFF_ENC_EN
                        diff_reg       <= 1'b1;
`endif
                    end
                end
                PRE, DATA: begin
                    sym_cnt_reg <= sym_end ? '0 : sym_cnt_reg + 1'b1;
                    if (byte_load && src_avail) begin
                        state_reg      <= DATA;
                        shift_reg      <= src_byte;
                        cur_last_reg   <= src_last;
                        sym_idx_reg    <= '0;
                        base_sig_reg   <= enc_bit ? SYM_POS : SYM_NEG;
                        sym_strobe_reg <= 1'b1;
`ifdef DIFF_ENC_EN
                        diff_reg       <= enc_bit;
`endif
                    end else if (byte_load || last_done) begin
                        // Starved boundary flags underrun; a tagged last byte ends quietly.
                        underrun_reg <= byte_load;
                        state_reg    <= GAP;
                        base_sig_reg <= SYM_OFF;
                        duc_en_reg   <= 1'b0;
                        sym_idx_reg  <= '0;
                    end else if (sym_end) begin
                        sym_idx_reg    <= sym_idx_reg + 1'b1;
                        sym_strobe_reg <= 1'b1;
                        if (state_reg == PRE) begin
                            base_sig_reg <= sym_idx_reg[0] ? SYM_POS : SYM_NEG;
`ifdef DIFF_ENC_EN
                            diff_reg     <= sym_idx_reg[0];
`endif
                        end else begin
                            shift_reg    <= {shift_reg[6:0], 1'b0};
                            base_sig_reg <= enc_bit ? SYM_POS : SYM_NEG;
`ifdef DIFF_ENC_EN
                            diff_reg     <= enc_bit;
`endif
                        end
                    end
                end
                GAP: begin
                    sym_cnt_reg <= sym_end ? '0 : sym_cnt_reg + 1'b1;
                    if (sym_end) begin
                        if (sym_idx_reg == IW'(GAP_LEN - 1)) begin
                            state_reg      <= IDLE;
                            frame_done_reg <= 1'b1;
                            busy_reg       <= 1'b0;
                            // A byte pushed after the tagged last byte is dropped so IDLE can restart.
                            hold_full_reg  <= 1'b0;
                        end else begin
                            sym_idx_reg <= sym_idx_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign base_sig   = base_sig_reg;
    assign duc_en     = duc_en_reg;
    assign sym_strobe = sym_strobe_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign underrun   = underrun_reg;
endmodule

// File: tb/tb_bpsk_tx_ctrl.sv
// Directed bench for bpsk_tx_ctrl: single-byte frame table plus multi-byte, underrun, bypass and reset sequences.
module tb_bpsk_tx_ctrl;
    localparam int SPS     = 4;
    localparam int PRE_LEN = 8;
    localparam int GAP_LEN = 4;
`ifdef DIFF_ENC_EN
    localparam bit DIFF_MODE = 1'b1;
`else
    localparam bit DIFF_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_last = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [1:0] base_sig;
    logic       duc_en;
    logic       sym_strobe;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    int n_checks = 0;
    int n_pass   = 0;
    int xfer_cnt = 0;
    logic [7:0] exp_pats [4];

    // data = byte sent with s_last, pat = expected sign of each data symbol MSB first (1 = +1)
    typedef struct {
        logic [7:0] data;
        logic [7:0] pat;
    } vec_t;
    vec_t vecs [6];

    bpsk_tx_ctrl #(.SPS(SPS), .PRE_LEN(PRE_LEN), .GAP_LEN(GAP_LEN), .BWIDTH(2)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .s_data(s_data), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready), .base_sig(base_sig), .duc_en(duc_en),
        .sym_strobe(sym_strobe), .busy(busy), .frame_done(frame_done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick(input logic [7:0] plain, input logic [7:0] diff);
        return DIFF_MODE ? diff : plain;
    endfunction

    function automatic logic [6:0] act_out();
        return {base_sig, duc_en, sym_strobe, busy, frame_done, underrun};
    endfunction

    // Expected {base_sig, duc_en, sym_strobe, busy, frame_done, underrun} t clocks after the start handshake
    function automatic logic [6:0] exp_out(input int t, input int n, input bit und);
        int sym, ph, d_end, g_end, k;
        logic b;
        sym   = t / SPS;
        ph    = t % SPS;
        d_end = PRE_LEN + 8 * n;
        g_end = d_end + GAP_LEN;
        if (t >= g_end * SPS) return 7'b00_0_0_0_1_0;
        if (sym < PRE_LEN) return {((sym % 2) == 0) ? 2'b01 : 2'b11, 1'b1, (ph == 0), 1'b1, 2'b00};
        if (sym < d_end) begin
            k = sym - PRE_LEN;
            b = exp_pats[k / 8][7 - (k % 8)];
            return {b ? 2'b01 : 2'b11, 1'b1, (ph == 0), 1'b1, 2'b00};
        end
        return {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, (und && (t == d_end * SPS))};
    endfunction

    task automatic start_frame(input logic [7:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_data = d; s_last = l; s_valid = 1'b1; tx_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        if (ok) tick;
        check("start_handshake", 32'(ok), 32'd1);
        s_valid = 1'b0;
        xfer_cnt = 1;
    endtask

    task automatic feed(input logic [7:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        s_data = d; s_last = l; s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        if (ok) begin tick; xfer_cnt++; end
        check("feed_handshake", 32'(ok), 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int n, input bit und);
        int total;
        total = (PRE_LEN + 8 * n + GAP_LEN) * SPS;
        for (int t = 0; t <= total; t++) begin
            check($sformatf("%s t=%0d", tag, t), 32'(act_out()), 32'(exp_out(t, n, und)));
            if (t < total) tick;
        end
        $display("frame %s: %0d bytes, underrun=%0d, checked %0d clks", tag, n, und, total + 1);
        tick;
    endtask

    initial begin
        int seen;
        vecs[0] = '{8'hA5, pick(8'hA5, 8'hC6)};
        vecs[1] = '{8'h00, pick(8'h00, 8'h00)};
        vecs[2] = '{8'hFF, pick(8'hFF, 8'hAA)};
        vecs[3] = '{8'h3C, pick(8'h3C, 8'h28)};
        vecs[4] = '{8'hF0, pick(8'hF0, 8'hA0)};
        vecs[5] = '{8'h81, pick(8'h81, 8'hFE)};

        // Reset state and ready gating
        tx_en = 1'b1;
        repeat (3) tick;
        @(negedge clk);
        check("reset_ready", 32'(s_ready), 32'd0);
        check("reset_outputs", 32'(act_out()), 32'd0);
        rst = 1'b0;
        tick;
        @(negedge clk);
        check("idle_ready_en", 32'(s_ready), 32'd1);
        tx_en = 1'b0;
        #1;
        check("idle_ready_dis", 32'(s_ready), 32'd0);
        tx_en = 1'b1;
        tick;

        // Single-byte frames from the table
        for (int i = 0; i < 6; i++) begin
            exp_pats[0] = vecs[i].pat;
            start_frame(vecs[i].data, 1'b1);
            check_frame($sformatf("vec%0d_%02h", i, vecs[i].data), 1, 1'b0);
        end

        // Three bytes, s_valid held high, tx_en dropped mid-frame
        exp_pats[0] = pick(8'h00, 8'h00);
        exp_pats[1] = pick(8'hFF, 8'hAA);
        exp_pats[2] = pick(8'h3C, 8'h28);
        start_frame(8'h00, 1'b0);
        fork
            check_frame("multi", 3, 1'b0);
            begin
                tx_en = 1'b0;
                feed(8'hFF, 1'b0);
                feed(8'h3C, 1'b1);
            end
        join
        check("multi_xfer_count", 32'(xfer_cnt), 32'd3);
        tx_en = 1'b1;

        // Second byte withheld: underrun at end of byte 1
        exp_pats[0] = pick(8'h96, 8'hE4);
        start_frame(8'h96, 1'b0);
        check_frame("underrun", 1, 1'b1);

        // Second byte presented only in the boundary cycle
        exp_pats[0] = pick(8'h3C, 8'h28);
        exp_pats[1] = pick(8'hC3, 8'h82);
        start_frame(8'h3C, 1'b0);
        fork
            check_frame("bypass", 2, 1'b0);
            begin
                repeat ((PRE_LEN + 8) * SPS - 1) tick;
                s_data = 8'hC3; s_last = 1'b1; s_valid = 1'b1;
                @(negedge clk);
                check("bypass_ready", 32'(s_ready), 32'd1);
                tick;
                s_valid = 1'b0;
            end
        join

        // Reset two clocks into DATA
        start_frame(8'h55, 1'b0);
        repeat (PRE_LEN * SPS + 2) tick;
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready_low", 32'(s_ready), 32'd0);
        tick;
        check("rst_abort_outputs", 32'(act_out()), 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (busy || frame_done || underrun || duc_en) seen++;
        end
        check("rst_no_activity", 32'(seen), 32'd0);
        exp_pats[0] = vecs[0].pat;
        start_frame(vecs[0].data, 1'b1);
        check_frame("after_rst", 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
